// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command arbiter.
package lcd_pkg;
  localparam int LCD_CMD_W    = 10;
  localparam int RS_BIT       = 9;
  localparam int RW_BIT       = 8;
  localparam int CLK_FREQ     = 360;
  // The controller's enable sequence runs 50 units of CLK_FREQ cycles; add margin.
  localparam int HOLD_DEFAULT = 50 * CLK_FREQ + 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    HOLD     = 3'd4
  } arb_state_t;

  // Round-robin successor of index i among n requesters.
  function automatic logic [1:0] next_ptr(input logic [1:0] i, input int n);
    return (int'(i) + 1 >= n) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/lcd_cmd_arbiter_if.sv
// Issue bus between the arbiter and the character-LCD controller.
interface lcd_cmd_arbiter_if;
  import lcd_pkg::*;
  logic                 lcd_enable;
  logic [LCD_CMD_W-1:0] lcd_bus;
  logic                 lcd_busy;

  modport master (output lcd_enable, output lcd_bus, input lcd_busy);
  modport slave  (input lcd_enable, input lcd_bus, output lcd_busy);
endinterface

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr.
module lcd_rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [1:0]       idx,
  output logic             any
);
  // Scan from the pointer, wrapping, and stop at the first hit.
  always_comb begin
    int j;
    gnt_oh = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = 2'(j);
        gnt_oh[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin sharing of one character-LCD controller among N_REQ clients.
// The controller's busy only marks the accept cycle, so a hold-off window
// covers its enable sequence before the next command is issued.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ-1:0][LCD_CMD_W-1:0]   cmd,
  output logic [N_REQ-1:0]                  gnt,
  output logic [N_REQ-1:0]                  done,
  output logic                              err,
  output logic [1:0]                        owner,
  output logic                              active,
  lcd_cmd_arbiter_if.master                 lcd
);
  arb_state_t           state;
  logic [1:0]           ptr;
  logic [CNT_W-1:0]     cnt;
  logic [LCD_CMD_W-1:0] cmd_q;
  logic [N_REQ-1:0]     own_oh;

  logic [N_REQ-1:0]     pick_oh;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic [LCD_CMD_W-1:0] cmd_sel;

  lcd_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // One-hot mux of the winning client's command slice.
  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_oh[i]) cmd_sel = cmd_sel | cmd[i];
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      cmd_q          <= '0;
      own_oh         <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      owner          <= '0;
      active         <= 1'b0;
      lcd.lcd_enable <= 1'b0;
      lcd.lcd_bus    <= '0;
    end else begin
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      lcd.lcd_enable <= 1'b0;
      case (state)
        IDLE: if (!lcd.lcd_busy && (|req)) state <= ARB;
        ARB: begin
          if (pick_any) begin
            gnt    <= pick_oh;
            own_oh <= pick_oh;
            cmd_q  <= cmd_sel;
            owner  <= pick_idx;
            active <= 1'b1;
            ptr    <= next_ptr(pick_idx, N_REQ);
            state  <= ISSUE;
          end else begin
            state  <= IDLE;
          end
        end
        ISSUE: begin
          lcd.lcd_enable <= 1'b1;
          lcd.lcd_bus    <= cmd_q;
          cnt            <= '0;
          state          <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Busy seen while our own strobe is on the bus is not an ack.
          if (lcd.lcd_busy && !lcd.lcd_enable) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
            err    <= 1'b1;
            active <= 1'b0;
            state  <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            done   <= own_oh;
            active <= 1'b0;
            state  <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench with a command scoreboard for lcd_cmd_arbiter.
module tb_lcd_cmd_arbiter;
  import lcd_pkg::*;

  localparam int N  = 2;
  localparam int HC = 1000;
  localparam int AT = 8;

  typedef struct {
    logic [1:0] idx;
    logic [9:0] cmd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0][9:0] cmd = '0;
  logic [N-1:0]    gnt, done;
  logic            err, active;
  logic [1:0]      owner;

  lcd_cmd_arbiter_if lcd_if ();

  lcd_cmd_arbiter #(.N_REQ(N), .HOLD_CYCLES(HC), .ACK_TIMEOUT(AT), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .cmd    (cmd),
    .gnt    (gnt),
    .done   (done),
    .err    (err),
    .owner  (owner),
    .active (active),
    .lcd    (lcd_if)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic en_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle structural properties of the outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ($onehot0(gnt) && $onehot0(done) &&
              (int'(|gnt) + int'(|done) + int'(err)) <= 1 &&
              !(lcd_if.lcd_enable && en_prev)) else begin
        failures++;
        $error("FAIL excl gnt=%b done=%b err=%b en=%b en_prev=%b", gnt, done, err,
               lcd_if.lcd_enable, en_prev);
      end
      en_prev = lcd_if.lcd_enable;
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic wait_gnt(input string tag, input logic [1:0] exp, input int budget, output int n);
    bit stray;
    n = 0;
    stray = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (done != 0 || err) stray = 1;
    end while (gnt == 0 && n < budget);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp));
    chk({tag, "_nostray"}, 32'(stray), 0);
  endtask

  // Follow one issued command: check the strobe against the scoreboard, then
  // either ack it (ack_dly cycles after the strobe) or let it time out.
  task automatic serve(input string tag, input int ack_dly, input bit issue_busy,
                       input logic [1:0] exp_done, input int abort, output time t_en);
    exp_t e;
    int   n;
    n = 0;
    while (!lcd_if.lcd_enable && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    t_en = $time;
    chk({tag, "_en"}, 32'(lcd_if.lcd_enable), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_bus"}, 32'(lcd_if.lcd_bus), 32'(e.cmd));
    chk({tag, "_owner"}, 32'(owner), 32'(e.idx));
    if (ack_dly > 0) begin
      repeat (ack_dly) begin @(posedge clk); #1; end
      lcd_if.lcd_busy = 1'b1;
      @(posedge clk); #1;
      lcd_if.lcd_busy = 1'b0;
      if (abort > 0) begin
        repeat (abort) begin @(posedge clk); #1; end
        return;
      end
      n = 0;
      do begin @(posedge clk); #1; n++; end while (done == 0 && !err && n < HC + 20);
      chk({tag, "_hold_len"}, 32'(n), 32'(HC));
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      chk({tag, "_noerr"}, 32'(err), 0);
      chk({tag, "_active"}, 32'(active), 0);
    end else begin
      n = 0;
      if (issue_busy) begin
        lcd_if.lcd_busy = 1'b1;
        @(posedge clk); #1;
        lcd_if.lcd_busy = 1'b0;
        n = 1;
        if (err) n = 100;
      end
      while (!err && done == 0 && n < 30) begin @(posedge clk); #1; n++; end
      chk({tag, "_to_len"}, 32'(n), AT + 1);
      chk({tag, "_err"}, 32'(err), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
      chk({tag, "_active"}, 32'(active), 0);
    end
  endtask

  initial begin
    int   n;
    bit   bad;
    time  t0, t1;
    exp_t e;

    lcd_if.lcd_busy = 1'b1;
    cmd[0] = 10'h241;
    cmd[1] = 10'h13c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", 32'({gnt, done, err, lcd_if.lcd_enable}), 0);
    chk("rst_bus", 32'(lcd_if.lcd_bus), 0);
    chk("rst_owner_active", 32'({owner, active}), 0);
    rst_n = 1'b1;

    // Controller still initialising: request must wait.
    req = 2'b01;
    e.idx = 2'd0; e.cmd = cmd[0]; sb.push_back(e);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (gnt != 0 || lcd_if.lcd_enable || active) bad = 1;
    end
    chk("init_blocked", 32'(bad), 0);
    lcd_if.lcd_busy = 1'b0;
    wait_gnt("init", 2'b01, 20, n);
    chk("init_gnt_lat", 32'(n), 2);
    chk("init_active", 32'(active), 1);
    req = 2'b00;
    serve("init", 1, 0, 2'b01, 0, t0);
    chk("init_bus_held", 32'(lcd_if.lcd_bus), 32'(10'h241));

    // Single command from client 1 with a longer ack latency.
    req = 2'b10;
    e.idx = 2'd1; e.cmd = cmd[1]; sb.push_back(e);
    wait_gnt("single1", 2'b10, 20, n);
    chk("single1_lat", 32'(n), 2);
    req = 2'b00;
    serve("single1", 3, 0, 2'b10, 0, t0);

    // Both clients request continuously: strict alternation from pointer 0.
    cmd[0] = 10'h048;
    cmd[1] = 10'h369;
    req = 2'b11;
    t1 = 0;
    for (int k = 0; k < 4; k++) begin
      e.idx = 2'(k % 2); e.cmd = cmd[k % 2]; sb.push_back(e);
      wait_gnt($sformatf("rr%0d", k), 2'(1 << (k % 2)), HC + 50, n);
      if (k == 3) req = 2'b00;
      serve($sformatf("rr%0d", k), 1, 0, 2'(1 << (k % 2)), 0, t0);
      if (k > 0) chk($sformatf("rr%0d_spacing", k), 32'(t0 - t1 >= (HC + 3) * 10), 1);
      t1 = t0;
    end

    // No ack at all: timeout error, no done.
    @(posedge clk); #1;
    req = 2'b01;
    e.idx = 2'd0; e.cmd = cmd[0]; sb.push_back(e);
    wait_gnt("to", 2'b01, 20, n);
    chk("to_lat", 32'(n), 2);
    req = 2'b00;
    serve("to", 0, 0, 2'b00, 0, t0);

    // Busy only alongside the strobe is not an ack.
    req = 2'b10;
    e.idx = 2'd1; e.cmd = cmd[1]; sb.push_back(e);
    wait_gnt("isb", 2'b10, 20, n);
    req = 2'b00;
    serve("isb", 0, 1, 2'b00, 0, t0);

    // Reset 500 cycles into the hold-off window.
    req = 2'b10;
    e.idx = 2'd1; e.cmd = cmd[1]; sb.push_back(e);
    wait_gnt("midrst", 2'b10, 20, n);
    req = 2'b00;
    serve("midrst", 1, 0, 2'b10, 500, t0);
    chk("midrst_pre_active", 32'(active), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_zero", 32'({gnt, done, err, lcd_if.lcd_enable, active, owner}), 0);
    chk("midrst_bus", 32'(lcd_if.lcd_bus), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cmd[1] = 10'h2aa;
    req = 2'b10;
    e.idx = 2'd1; e.cmd = cmd[1]; sb.push_back(e);
    wait_gnt("post", 2'b10, 20, n);
    req = 2'b00;
    serve("post", 1, 0, 2'b10, 0, t0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
